// File: rtl/crc32_frame_checker.sv
// -----------------------------------------------------------------------------
// crc32_frame_checker
//   Receive-side CRC-32 checker for a sop/eop framed byte stream, one byte per
//   clock. The last four bytes of each frame are the FCS, LSB first. Running
//   the FCS through the same reflected CRC register leaves a constant residue
//   (0xDEBB20E3) on an intact frame. The check uses that residue, so the
//   checker never needs to know where the payload ends.
//
//   Each completed frame produces one result: ok / runt / length. The result
//   is held until it is accepted on the res_valid/res_ready handshake. While a
//   result is pending, in_ready is low.
//
//   Optional feature macro: CRC32_CHK_STAT_EN
//     defined   -> 32-bit wrapping good/bad frame counters on stat_good/stat_bad
//     undefined -> stat_good/stat_bad tied to zero, no counters built
// -----------------------------------------------------------------------------
module crc32_frame_checker #(
   parameter int LEN_W   = 16,
   parameter int MIN_LEN = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic             in_sop,
   input  logic             in_eop,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_ok,
   output logic             res_runt,
   output logic [LEN_W-1:0] res_len,
   output logic [31:0]      stat_good,
   output logic [31:0]      stat_bad
);

   localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
   localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
   localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_RESULT = 2'd2
   } state_t;

   // Reflected CRC-32 table entry: eight shift/xor steps applied to one byte.
   function automatic logic [31:0] table_entry(input logic [7:0] idx);
      logic [31:0] c;
      c = {24'd0, idx};
      for (int b = 0; b < 8; b++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction

   // ---------------------------------------------------------------------------
   // Lookup table
   // ---------------------------------------------------------------------------
   // NOTE: the table is elaborated from constants, so it is plain logic with
   // no storage. It is never reset or written, and no clock is involved.
   logic [31:0] crc_table [256];

   for (genvar g = 0; g < 256; g++) begin : g_table
      assign crc_table[g] = table_entry(8'(g));
   end

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   state_t           state, state_n;
   logic [31:0]      crc, crc_n;
   logic [LEN_W-1:0] len, len_n;

   logic             beat;
   logic             res_load;
   logic             res_take;
   logic [7:0]       seed_idx;
   logic [7:0]       upd_idx;
   logic [31:0]      crc_seed;
   logic [31:0]      crc_upd;
   logic [LEN_W-1:0] len_inc;

   assign res_valid = (state == S_RESULT);
   assign in_ready  = ~res_valid;
   assign beat      = in_valid & in_ready;
   assign res_take  = res_valid & res_ready;

   // Two candidate CRC updates: restarting from the initial value on sop, or
   // continuing the running CRC. Each is a single combinational lookup.
   assign seed_idx = CRC_INIT[7:0] ^ in_data;
   assign upd_idx  = crc[7:0] ^ in_data;
   assign crc_seed = crc_table[seed_idx] ^ {8'h00, CRC_INIT[31:8]};
   assign crc_upd  = crc_table[upd_idx] ^ {8'h00, crc[31:8]};

   // The length counter sticks at all-ones instead of wrapping.
   assign len_inc = (len == LEN_MAX) ? len : (len + LEN_ONE);

   // Next-state and next-datapath values for the frame FSM.
   always_comb begin
      // NOTE: every output of this block gets a default first. Without the
      // defaults, a path that skips an assignment would infer a latch.
      state_n = state;
      crc_n   = crc;
      len_n   = len;

      unique case (state)
         S_IDLE: begin
            // A byte without sop is accepted here and thrown away.
            if (beat && in_sop) begin
               crc_n   = crc_seed;
               len_n   = LEN_ONE;
               state_n = in_eop ? S_RESULT : S_DATA;
            end
         end

         S_DATA: begin
            if (beat) begin
               if (in_sop) begin
                  // A new sop aborts the open frame. That frame gives no result.
                  crc_n = crc_seed;
                  len_n = LEN_ONE;
               end else begin
                  crc_n = crc_upd;
                  len_n = len_inc;
               end
               if (in_eop) begin
                  state_n = S_RESULT;
               end
            end
         end

         S_RESULT: begin
            if (res_ready) begin
               crc_n   = CRC_INIT;
               len_n   = '0;
               state_n = S_IDLE;
            end
         end

         default: begin
            crc_n   = CRC_INIT;
            len_n   = '0;
            state_n = S_IDLE;
         end
      endcase
   end

   // The result fields are captured on the eop beat, i.e. on entry to RESULT.
   assign res_load = (state != S_RESULT) && (state_n == S_RESULT);

   // FSM state, running CRC and length registers.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state is written with non-blocking assignments only.
      // All registers then update together on the edge, with no ordering race.
      if (rst) begin
         state <= S_IDLE;
         crc   <= CRC_INIT;
         len   <= '0;
      end else begin
         state <= state_n;
         crc   <= crc_n;
         len   <= len_n;
      end
   end

   // Result register. The fields are held unchanged for the whole of RESULT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_ok   <= 1'b0;
         res_runt <= 1'b0;
         res_len  <= '0;
      end else if (res_load) begin
         res_runt <= (len_n < LEN_MIN);
         res_ok   <= (crc_n == CRC_RESIDUE) && (len_n >= LEN_MIN);
         res_len  <= len_n;
      end
   end

`ifdef CRC32_CHK_STAT_EN
   logic [31:0] good_cnt;
   logic [31:0] bad_cnt;

   // Good/bad frame counters. They advance once per accepted result and wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         good_cnt <= '0;
         bad_cnt  <= '0;
      end else if (res_take) begin
         if (res_ok) begin
            good_cnt <= good_cnt + 32'd1;
         end else begin
            bad_cnt  <= bad_cnt + 32'd1;
         end
      end
   end

   assign stat_good = good_cnt;
   assign stat_bad  = bad_cnt;
`else
   // No counters in this build. The statistic ports read as zero, and the
   // handshake term has no load in this build, so it is folded into a
   // constant-zero reduction.
   logic unused_take;
   assign unused_take = res_take & 1'b0;
   assign stat_good   = {31'd0, unused_take};
   assign stat_bad    = '0;
`endif

endmodule

// File: tb/tb_crc32_frame_checker.sv
// -----------------------------------------------------------------------------
// tb_crc32_frame_checker
//   Scoreboard bench. The stimulus side feeds bytes to a frame-level reference
//   model: a bitwise CRC over a byte queue. On each accepted eop the model
//   pushes an expected result into a queue. A separate monitor pops that queue
//   on every result handshake. The monitor also checks the 1-clk latency,
//   result stability under back-pressure, and in_ready across RESULT.
// -----------------------------------------------------------------------------
module tb_crc32_frame_checker;

   localparam int LEN_W   = 16;
   localparam int MIN_LEN = 5;

   typedef struct packed {
      logic             ok;
      logic             runt;
      logic [LEN_W-1:0] len;
   } res_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [7:0]       in_data = 8'h00;
   logic             in_sop = 1'b0;
   logic             in_eop = 1'b0;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic             res_ok;
   logic             res_runt;
   logic [LEN_W-1:0] res_len;
   logic [31:0]      stat_good;
   logic [31:0]      stat_bad;

   crc32_frame_checker #(.LEN_W(LEN_W), .MIN_LEN(MIN_LEN)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sop    (in_sop),
      .in_eop    (in_eop),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_ok    (res_ok),
      .res_runt  (res_runt),
      .res_len   (res_len),
      .stat_good (stat_good),
      .stat_bad  (stat_bad)
   );

   always #5 clk = ~clk;

   int          vectors     = 0;
   int          miscompares = 0;
   int          cyc         = 0;
   int          eop_cyc     = -10;
   int          rr_mode     = 0;       // 0 random, 1 always ready, 2 stalled
   res_t        exp_q[$];
   logic [7:0]  frame_q[$];
   bit          in_frame    = 1'b0;
   int unsigned model_good  = 0;
   int unsigned model_bad   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference CRC, bit-serial reflected CRC-32 with no final inversion.
   function automatic logic [31:0] ref_crc(input logic [7:0] q[$]);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      foreach (q[i]) begin
         c = c ^ {24'd0, q[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return c;
   endfunction

   // Frame-level model, called for every accepted byte.
   task automatic model_beat(input logic [7:0] d, input logic sop, input logic eop);
      res_t r;
      if (sop) begin
         frame_q.delete();
         in_frame = 1'b1;
      end else if (!in_frame) begin
         return;
      end
      frame_q.push_back(d);
      if (eop) begin
         r.len  = (frame_q.size() > 65535) ? 16'hFFFF : LEN_W'(frame_q.size());
         r.runt = (frame_q.size() < MIN_LEN);
         r.ok   = (ref_crc(frame_q) == 32'hDEBB_20E3) && !r.runt;
         exp_q.push_back(r);
         in_frame = 1'b0;
         eop_cyc  = cyc + 1;
      end
   endtask

   // Drive one byte until it is accepted. Sometimes leave in_valid low first.
   task automatic send_byte(input logic [7:0] d, input logic sop, input logic eop, input int gap_pct);
      for (int tries = 0; tries < 1000; tries++) begin
         @(negedge clk);
         if ($urandom_range(0, 99) < gap_pct) begin
            in_valid = 1'b0;
            continue;
         end
         in_valid = 1'b1;
         in_data  = d;
         in_sop   = sop;
         in_eop   = eop;
         if (in_ready) begin
            model_beat(d, sop, eop);
            return;
         end
      end
      check("in_ready_timeout", in_ready, 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_sop   = 1'b0;
         in_eop   = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [7:0] f[$], input int gap_pct);
      foreach (f[i]) send_byte(f[i], i == 0, i == f.size() - 1, gap_pct);
      idle(1);
   endtask

   // Random payload followed by its FCS (inverted CRC, LSB first).
   // Optionally one bit anywhere in the frame is flipped.
   task automatic make_frame(input int n, input bit corrupt, output logic [7:0] f[$]);
      logic [31:0] fcs;
      int          k;
      logic [7:0]  b;
      f.delete();
      for (int i = 0; i < n; i++) f.push_back(8'($urandom));
      fcs = ~ref_crc(f);
      for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
      if (corrupt) begin
         k    = $urandom_range(0, f.size() - 1);
         b    = f[k];
         b    = b ^ (8'h01 << $urandom_range(0, 7));
         f[k] = b;
      end
   endtask

   // Result back-pressure, changed just after each rising edge.
   always begin
      @(posedge clk);
      #1;
      case (rr_mode)
         1:       res_ready = 1'b1;
         2:       res_ready = 1'b0;
         default: res_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   // Scoreboard monitor, sampling on the falling edge.
   res_t held;
   bit   hold_pending = 1'b0;
   bit   after_hs     = 1'b0;

   always @(negedge clk) begin
      res_t e;
      if (rst) begin
         hold_pending = 1'b0;
         after_hs     = 1'b0;
      end else begin
         if (eop_cyc == cyc) check("latency_res_valid", res_valid, 1'b1);
         if (after_hs) begin
            check("in_ready_after_take", in_ready, 1'b1);
            check("res_valid_after_take", res_valid, 1'b0);
`ifdef CRC32_CHK_STAT_EN
            check("stat_good", stat_good, model_good);
            check("stat_bad", stat_bad, model_bad);
`else
            check("stat_good_tied", stat_good, 0);
            check("stat_bad_tied", stat_bad, 0);
`endif
            after_hs = 1'b0;
         end
         if (res_valid) begin
            check("in_ready_in_result", in_ready, 1'b0);
            if (hold_pending) begin
               check("hold_ok", res_ok, held.ok);
               check("hold_runt", res_runt, held.runt);
               check("hold_len", res_len, held.len);
            end
            if (exp_q.size() == 0) begin
               check("unexpected_result", res_valid, 1'b0);
               hold_pending = 1'b0;
            end else if (res_ready) begin
               e = exp_q.pop_front();
               check("res_ok", res_ok, e.ok);
               check("res_runt", res_runt, e.runt);
               check("res_len", res_len, e.len);
               if (e.ok) model_good++;
               else      model_bad++;
               after_hs     = 1'b1;
               hold_pending = 1'b0;
            end else begin
               held         = '{ok: res_ok, runt: res_runt, len: res_len};
               hold_pending = 1'b1;
            end
         end else if (hold_pending) begin
            check("res_valid_held", res_valid, 1'b1);
            hold_pending = 1'b0;
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_res_valid"}, res_valid, 1'b0);
      check({tag, "_res_ok"}, res_ok, 1'b0);
      check({tag, "_res_runt"}, res_runt, 1'b0);
      check({tag, "_res_len"}, res_len, 0);
      check({tag, "_stat_good"}, stat_good, 0);
      check({tag, "_stat_bad"}, stat_bad, 0);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
      check({tag, "_drain_pending"}, exp_q.size(), 0);
   endtask

   logic [7:0] case1[$];
   logic [7:0] f[$];

   initial begin
      case1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                8'h26, 8'h39, 8'hF4, 8'hCB};

      // Reset state
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      check("reset_in_ready", in_ready, 1'b1);
      rst = 1'b0;
      idle(2);

      // Case 1: known-good frame, always ready
      rr_mode = 1;
      send_frame(case1, 0);
      drain("case1");

      // Case 2: one bit flipped in byte 3
      f = case1;
      f[3] = f[3] ^ 8'h01;
      send_frame(f, 0);
      drain("case2");

      // Case 3: 3-byte runt
      f = '{8'h01, 8'h02, 8'h03};
      send_frame(f, 0);
      drain("case3");

      // Single-beat frame
      f = '{8'hA5};
      send_frame(f, 0);
      drain("single");

      // Case 4: result stalled for several clocks
      rr_mode = 2;
      send_frame(case1, 0);
      idle(6);
      rr_mode = 1;
      drain("case4");

      // Case 5: restart at byte 4, then a full frame
      for (int i = 0; i < 4; i++) send_byte(case1[i], i == 0 || i == 3, 1'b0, 0);
      send_frame(case1, 0);
      drain("case5");

      // Bytes without sop in IDLE are dropped
      for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0, i == 2, 0);
      idle(2);
      send_frame(case1, 0);
      drain("drop");

      // Case 6: reset mid-frame, then a good frame
      for (int i = 0; i < 6; i++) send_byte(case1[i], i == 0, 1'b0, 0);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      frame_q.delete();
      in_frame = 1'b0;
      exp_q.delete();
      model_good = 0;
      model_bad  = 0;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      rst = 1'b0;
      idle(2);
      check("after_rst_res_valid", res_valid, 1'b0);
      send_frame(case1, 0);
      drain("case6");

      // Randomized traffic with gaps and back-pressure
      rr_mode = 0;
      for (int n = 0; n < 150; n++) begin
         int kind;
         kind = $urandom_range(0, 9);
         case (kind)
            6: begin
               make_frame($urandom_range(1, 20), 1'b1, f);
               send_frame(f, 20);
            end
            7: begin
               f.delete();
               repeat ($urandom_range(1, 8)) f.push_back(8'($urandom));
               send_frame(f, 20);
            end
            8: begin
               make_frame($urandom_range(1, 10), 1'b0, f);
               for (int i = 0; i < $urandom_range(1, f.size() - 1); i++)
                  send_byte(f[i], i == 0, 1'b0, 20);
            end
            9: begin
               repeat ($urandom_range(1, 4)) send_byte(8'($urandom), 1'b0, 1'($urandom), 20);
            end
            default: begin
               make_frame($urandom_range(1, 20), 1'b0, f);
               send_frame(f, 20);
            end
         endcase
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      rr_mode = 1;
      idle(2);
      drain("random");
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
